// File: rtl/aes_keyexp_master.sv
// aes_keyexp_master: AES-128 key expansion engine acting as a data-memory bus master.
// Reads the cipher key, S-box and Rcon tables from memory and writes w[4]..w[4*ROUNDS+3]
// back in place. Optional read-back checking is compiled in with AES_KEYEXP_READBACK_EN.
module aes_keyexp_master #(
    parameter logic [31:0] KEY_BASE  = 32'd0,
    parameter logic [31:0] EXP_BASE  = 32'd4,
    parameter logic [31:0] RCON_BASE = 32'd114,
    parameter logic [31:0] SBOX_BASE = 32'd128,
    parameter int          ROUNDS    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_re,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        RCON,
        WRITE,
        VERIFY,
        DONE
    } state_t;

    localparam logic [5:0] LAST_I = 6'(4 * ROUNDS + 3);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] win [4];
    logic [5:0]  i_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] temp;
    logic [31:0] word_val;
    logic [31:0] word_idx;
    logic [7:0]  sub_byte;
    logic [1:0]  rot_sel;
    logic [5:0]  rcon_idx;

`ifdef AES_KEYEXP_READBACK_EN
    logic [31:0] wr_last;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Word being produced: first word of a round uses the substituted temp, others chain win[3].
    assign word_val = win[0] ^ ((i_cnt[1:0] == 2'd0) ? temp : win[3]);
    assign rot_sel  = byte_cnt + 2'd1;
    assign rcon_idx = (i_cnt >> 2) - 6'd1;
    assign mem_addr = word_idx << 2;

    // RotWord byte selection from the newest window word; byte 0 is the most significant.
    always_comb begin
        sub_byte = 8'h00;
        case (rot_sel)
            2'd0: sub_byte = win[3][31:24];
            2'd1: sub_byte = win[3][23:16];
            2'd2: sub_byte = win[3][15:8];
            2'd3: sub_byte = win[3][7:0];
            default: sub_byte = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus outputs, decoded purely from registered state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_re    = 1'b0;
        mem_wr    = 1'b0;
        word_idx  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                word_idx = KEY_BASE + {30'd0, byte_cnt};
                if (byte_cnt == 2'd3) begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                word_idx = SBOX_BASE + {24'd0, sub_byte};
                if (byte_cnt == 2'd3) begin
                    state_nxt = RCON;
                end
            end
            RCON: begin
                busy      = 1'b1;
                mem_re    = 1'b1;
                word_idx  = RCON_BASE + {26'd0, rcon_idx};
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                word_idx  = EXP_BASE + {26'd0, i_cnt} - 32'd4;
                mem_wdata = word_val;
`ifdef AES_KEYEXP_READBACK_EN
                state_nxt = VERIFY;
`else
                if (i_cnt == LAST_I) begin
                    state_nxt = DONE;
                end else if (i_cnt[1:0] == 2'd3) begin
                    state_nxt = SUB;
                end else begin
                    state_nxt = WRITE;
                end
`endif
            end
`ifdef AES_KEYEXP_READBACK_EN
            VERIFY: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                word_idx = EXP_BASE + {26'd0, i_cnt} - 32'd5;
                if (i_cnt == LAST_I + 6'd1) begin
                    state_nxt = DONE;
                end else if (i_cnt[1:0] == 2'd0) begin
                    state_nxt = SUB;
                end else begin
                    state_nxt = WRITE;
                end
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: key window, counters, substitution temp and read-back error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win[0]   <= 32'd0;
            win[1]   <= 32'd0;
            win[2]   <= 32'd0;
            win[3]   <= 32'd0;
            i_cnt    <= 6'd0;
            byte_cnt <= 2'd0;
            temp     <= 32'd0;
`ifdef AES_KEYEXP_READBACK_EN
            wr_last  <= 32'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt <= 2'd0;
                        i_cnt    <= 6'd0;
`ifdef AES_KEYEXP_READBACK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    win[0]   <= win[1];
                    win[1]   <= win[2];
                    win[2]   <= win[3];
                    win[3]   <= mem_rdata;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        i_cnt <= 6'd4;
                    end
                end
                SUB: begin
                    case (byte_cnt)
                        2'd0: temp[31:24] <= mem_rdata[7:0];
                        2'd1: temp[23:16] <= mem_rdata[7:0];
                        2'd2: temp[15:8]  <= mem_rdata[7:0];
                        2'd3: temp[7:0]   <= mem_rdata[7:0];
                        default: ;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                end
                RCON: begin
                    temp <= temp ^ {mem_rdata[7:0], 24'h000000};
                end
                WRITE: begin
                    win[0] <= win[1];
                    win[1] <= win[2];
                    win[2] <= win[3];
                    win[3] <= word_val;
                    i_cnt  <= i_cnt + 6'd1;
`ifdef AES_KEYEXP_READBACK_EN
                    wr_last <= word_val;
`endif
                end
`ifdef AES_KEYEXP_READBACK_EN
                VERIFY: begin
                    if (mem_rdata != wr_last) begin
                        err_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_keyexp_master.sv
// tb_aes_keyexp_master: self-checking bench for aes_keyexp_master with a word-addressed
// memory model. Expected bus traffic and key words come from a FIPS-197 style model.
module tb_aes_keyexp_master;

`ifdef AES_KEYEXP_READBACK_EN
    localparam int LAT = 134;
`else
    localparam int LAT = 94;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err, mem_re, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        bit          re;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          corrupt;
    } busOp_t;

    busOp_t          expTrace[$];
    logic [31:0]     mem [0:511];
    logic [0:255][7:0] sboxTab;
    logic [7:0]      rconTab [0:9];
    logic [31:0]     keyWords [0:3];
    logic [31:0]     expW [0:43];
    bit              memInitReq = 1'b0;
    bit              corruptOn = 1'b0;
    int              writeTotal = 0;
    int              badWriteTotal = 0;
    int              readCnt = 0;
    logic [31:0]     firstReads [0:4];
    int              busyTotal = 0;
    bit              expErr = 1'b0;
    bit              errPending = 1'b0;
    int              checks = 0;
    int              errors = 0;

    aes_keyexp_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_re    (mem_re),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_re ? mem[mem_addr[10:2]] : 32'hdeadbeef;

    function automatic logic [31:0] initWord(input int a);
        if (a < 4) return keyWords[a];
        if (a >= 114 && a < 124) return {24'd0, rconTab[a - 114]};
        if (a >= 128 && a < 384) return {24'd0, sboxTab[a - 128]};
        return 32'd0;
    endfunction

    // Memory model with write capture, optional write corruption and first-read logging.
    always @(posedge clk) begin
        if (memInitReq) begin
            for (int a = 0; a < 512; a++) mem[a] <= initWord(a);
        end else if (mem_wr) begin
            mem[mem_addr[10:2]] <= (corruptOn && mem_addr == 32'h20) ? (mem_wdata ^ 32'h1) : mem_wdata;
        end
        if (mem_wr) begin
            writeTotal <= writeTotal + 1;
            if (mem_addr < 32'h10 || mem_addr > 32'hac) badWriteTotal <= badWriteTotal + 1;
        end
        if (start && !busy && !done) begin
            readCnt <= 0;
        end else if (mem_re && readCnt < 5) begin
            firstReads[readCnt] <= mem_addr;
            readCnt <= readCnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void pushOp(input bit re, input bit wr, input int addr, input logic [31:0] data, input bit corrupt);
        busOp_t op;
        op.re = re;
        op.wr = wr;
        op.addr = 32'(addr);
        op.data = data;
        op.corrupt = corrupt;
        expTrace.push_back(op);
    endfunction

    // Standard AES-128 key schedule over the bench's own tables.
    function automatic void buildModel();
        logic [31:0] t;
        for (int i = 0; i < 4; i++) expW[i] = keyWords[i];
        for (int i = 4; i < 44; i++) begin
            t = expW[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
                t[31:24] = t[31:24] ^ rconTab[i/4 - 1];
            end
            expW[i] = expW[i-4] ^ t;
        end
    endfunction

    // Expected per-busy-cycle bus transactions for one full expansion.
    function automatic void buildTrace(input bit corrupt);
        logic [31:0] rot;
        expTrace.delete();
        for (int k = 0; k < 4; k++) pushOp(1, 0, k * 4, 32'd0, 0);
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0) begin
                rot = {expW[i-1][23:0], expW[i-1][31:24]};
                for (int k = 0; k < 4; k++) pushOp(1, 0, (128 + int'(rot[31 - 8*k -: 8])) * 4, 32'd0, 0);
                pushOp(1, 0, (114 + i/4 - 1) * 4, 32'd0, 0);
            end
            pushOp(0, 1, i * 4, expW[i], 0);
`ifdef AES_KEYEXP_READBACK_EN
            pushOp(1, 0, i * 4, 32'd0, corrupt && (i * 4 == 32'h20));
`endif
        end
    endfunction

    task automatic compareCycle();
        busOp_t op;
        if (!reset) begin
            expTrace.delete();
            errPending = 1'b0;
            expErr = 1'b0;
            checkOutput("reset_outputs", {27'd0, busy, done, err, mem_re, mem_wr}, 32'd0);
            return;
        end
        checkOutput("re_wr_exclusive", {31'd0, mem_re & mem_wr}, 32'd0);
        if (errPending) begin
            expErr = 1'b1;
            errPending = 1'b0;
        end
        checkOutput("err_flag", {31'd0, err}, {31'd0, expErr});
        if (busy) begin
            busyTotal++;
            if (expTrace.size() == 0) begin
                checkOutput("trace_overrun", 32'd1, 32'd0);
            end else begin
                op = expTrace.pop_front();
                checkOutput("bus_re", {31'd0, mem_re}, {31'd0, op.re});
                checkOutput("bus_wr", {31'd0, mem_wr}, {31'd0, op.wr});
                checkOutput("bus_addr", mem_addr, op.addr);
                if (op.wr) checkOutput("bus_wdata", mem_wdata, op.data);
                if (op.corrupt) errPending = 1'b1;
            end
        end else begin
            checkOutput("idle_strobes", {30'd0, mem_re, mem_wr}, 32'd0);
            checkOutput("idle_addr", mem_addr, 32'd0);
            checkOutput("idle_wdata", mem_wdata, 32'd0);
        end
    endtask

    // Per-cycle comparison against the expected transaction trace.
    initial begin
        forever begin
            @(negedge clk);
            compareCycle();
        end
    end

    task automatic applyStimulus(input bit accepted);
        @(negedge clk);
        #1;
        if (accepted) expErr = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic initMemory();
        @(negedge clk);
        #1;
        memInitReq = 1'b1;
        @(posedge clk);
        #1;
        memInitReq = 1'b0;
    endtask

    task automatic runFull(input string tag, input int midStart, input bit corrupt);
        int cyc, busy0, wr0, bad0;
        bit seen;
        logic [31:0] pinLo [0:3];
        logic [31:0] pinHi [0:3];
        logic [31:0] firstExp [0:4];
        logic [31:0] wantW;
        pinLo = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
        pinHi = '{32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
        firstExp = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h53c};
        buildTrace(corrupt);
        corruptOn = corrupt;
        busy0 = busyTotal;
        wr0 = writeTotal;
        bad0 = badWriteTotal;
        applyStimulus(1'b1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else if (cyc == midStart) begin
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        checkOutput($sformatf("%s_done_seen", tag), {31'd0, seen}, 32'd1);
        checkOutput($sformatf("%s_busy_cycles", tag), 32'(busyTotal - busy0), 32'(LAT));
        checkOutput($sformatf("%s_write_count", tag), 32'(writeTotal - wr0), 32'd40);
        checkOutput($sformatf("%s_bad_writes", tag), 32'(badWriteTotal - bad0), 32'd0);
        checkOutput($sformatf("%s_trace_left", tag), 32'(expTrace.size()), 32'd0);
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("%s_first_read%0d", tag, k), firstReads[k], firstExp[k]);
        @(negedge clk);
        checkOutput($sformatf("%s_done_width", tag), {30'd0, done, busy}, 32'd0);
        checkOutput($sformatf("%s_err_final", tag), {31'd0, err}, {31'd0, corrupt});
        for (int i = 4; i < 44; i++) begin
            wantW = (corrupt && i == 8) ? (expW[i] ^ 32'h1) : expW[i];
            checkOutput($sformatf("%s_w%0d", tag, i), mem[i], wantW);
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_pin_w%0d", tag, 4 + k), mem[4 + k], pinLo[k]);
            checkOutput($sformatf("%s_pin_w%0d", tag, 40 + k), mem[40 + k], pinHi[k]);
        end
    endtask

    // Main directed sequence.
    initial begin
        sboxTab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                   128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                   128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                   128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                   128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                   128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                   128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                   128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        rconTab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        keyWords = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
        buildModel();
        checkOutput("model_w4", expW[4], 32'ha0fafe17);
        checkOutput("model_w43", expW[43], 32'hb6630ca6);

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_status", {28'd0, busy, done, err, mem_re}, 32'd0);
        checkOutput("rst_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        #1 reset = 1'b1;

        initMemory();
        runFull("run1", -1, 1'b0);

        initMemory();
        runFull("run2_midstart", 30, 1'b0);

        buildTrace(1'b0);
        corruptOn = 1'b0;
        applyStimulus(1'b1);
        repeat (49) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("midrst_status", {28'd0, busy, done, mem_re, mem_wr}, 32'd0);
        checkOutput("midrst_addr", mem_addr, 32'd0);
        checkOutput("midrst_wdata", mem_wdata, 32'd0);
        checkOutput("midrst_partial_w4", mem[4], 32'ha0fafe17);
        @(negedge clk);
        #1 reset = 1'b1;

        initMemory();
        runFull("run3_after_reset", -1, 1'b0);

`ifdef AES_KEYEXP_READBACK_EN
        initMemory();
        runFull("run4_corrupt", -1, 1'b1);
        corruptOn = 1'b0;
        initMemory();
        runFull("run5_err_cleared", -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_keyexp_master.md
Name: aes_keyexp_master

Overview:
- Bus initiator that performs AES-128 key expansion in place in the data memory, using the memory's single-cycle load/store port.
- Reads the cipher key (words 0-3), S-box bytes and Rcon constants from memory. Computes w[4]..w[43] and writes them back to the expansion-key region.
- Sits beside the CPU as a second master on the data-memory port; arbitration is outside this block, so the block owns the port while busy=1.

Parameters:
KEY_BASE, 0, word index of cipher key w[0]
EXP_BASE, 4, word index where w[4] is written (w[i] at EXP_BASE+i-4)
RCON_BASE, 114, word index of Rcon[1] (value in bits 7:0)
SBOX_BASE, 128, word index of S-box entry 0 (entry b at SBOX_BASE+b, value in bits 7:0)
ROUNDS, 10, number of rounds; generates 4*ROUNDS words

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
busy  out  1  high while block owns memory port
done  out  1  one-cycle pulse after final write
err  out  1  sticky read-back mismatch flag (optional feature)
mem_re  out  1  read enable
mem_wr  out  1  write enable; memory captures on rising clk
mem_addr  out  32  byte address = word_index<<2; bits 1:0 always 0
mem_wdata  out  32  write data
mem_rdata  in  32  combinational read data, valid in same cycle as mem_re

Behaviour:
- Interface: reset is reset, asynchronous, active-low; clock is clk. Reset clears all state and outputs to 0 and returns the FSM to IDLE, including mid-operation. Partially written expansion words stay in memory.
- Memory outputs are decoded from registered state only (glitch-free). mem_re and mem_wr are never both 1. mem_addr, mem_wdata, mem_re and mem_wr are 0 in IDLE and DONE.
- Internal state: 4-word window win[0..3] = w[i-4..i-1], 6-bit word counter i (4..4*ROUNDS+3), 2-bit byte counter, temp register.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD; clears err.
  - LOAD: 4 cycles. Read KEY_BASE+k for k=0..3 and shift mem_rdata into the window. Then i=4 -> SUB.
  - SUB: entered only when i%4==0. 4 cycles. Cycle k reads SBOX_BASE+byte, where byte is byte (k+1)%4 of win[3] (RotWord); byte 0 is bits 31:24. Result bits 7:0 go into temp byte k (MSB first). -> RCON.
  - RCON: 1 cycle. Reads RCON_BASE+i/4-1. temp ^= {mem_rdata[7:0],24'h0}. -> WRITE.
  - WRITE: 1 cycle. mem_wr=1, address EXP_BASE+i-4, wdata = win[0] ^ (i%4==0 ? temp : win[3]). On the same edge the window shifts in wdata and i increments.
    - Next state: if i was 4*ROUNDS+3 -> DONE; else if new i%4==0 -> SUB; else -> WRITE.
  - DONE: 1 cycle; done=1, busy=0 -> IDLE.
- busy=1 in LOAD, SUB, RCON, WRITE (and VERIFY); 0 otherwise.
- Latency with default params, feature off: 4 + 10*(4+1+4) = 94 busy cycles, then the done pulse.
- start while busy or in DONE is ignored (no queuing).
- Rcon index arithmetic is 6-bit. With ROUNDS>10 the Rcon address walks past the table; this is unsupported and not checked.
- mem_rdata is ignored whenever mem_re=0.

Optional Feature:
- Macro AES_KEYEXP_READBACK_EN.
- Defined:
  - Every WRITE is followed by a 1-cycle VERIFY state that reads back the same address.
  - If mem_rdata != the value written, err is set and stays set until the next accepted start.
  - Sequencing continues regardless of mismatches.
  - VERIFY counts as busy; latency becomes 134 cycles.
- Undefined: no VERIFY state; err is tied to 0.

Test Plan:
- Reset memory model (key 2b7e1516 28aed2a6 abf71588 09cf4f3c, standard S-box, Rcon 01..36); pulse start -> writes w4=a0fafe17, w5=88542cb1, w6=23a33939, w7=2a6c7605 at byte addresses 0x10..0x1c.
- Same run -> w40=d014f9a8, w41=c9ee2589, w42=e13f0cc8, w43=b6630ca6 at 0xa0..0xac. done pulses exactly 1 cycle after 94 busy cycles; 40 writes total, no write outside 0x10..0xac.
- Protocol check across the run: mem_re & mem_wr never both 1; first read addresses 0x0,0x4,0x8,0xc; first S-box read at 0x200+(0xcf<<2)=0x53c.
- Pulse start again mid-run (cycle 30) -> ignored; results and timing identical to the first run.
- Assert reset at cycle 50 -> busy, done, mem_re, mem_wr drop to 0 immediately. A new start after release restarts from LOAD and produces correct w4..w43.
- With AES_KEYEXP_READBACK_EN, model corrupts the write to 0x20 -> err=1 from the VERIFY cycle onward, run completes in 134 cycles, next start clears err.
